// File: rtl/uart_pkg.sv
// Shared UART definitions: framer state encoding and default line format,
// used by both the RX and TX framers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter: counts while not cleared and raises a one-cycle
// sample strobe when the count reaches the supplied terminal value.
module uart_rx_bit_timer #(
    parameter  int CLKS_PER_BIT = 16,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = !clr && (cnt_q == term);

    // Wrap to zero on the strobe so the next bit period starts immediately.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start-bit qualification, mid-bit sampling of data,
// optional parity and stop bit, and registered byte/error pulses.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_level,
    input  logic                 rx_fall,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 rx_busy
);

    localparam int   CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int   IDX_W    = $clog2(DATA_BITS + 1);
    localparam int   HALF     = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    localparam logic PAR_EN  = (PARITY_EN != 0);

    uart_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 rx_busy_q, rx_busy_d;

    logic                 tmr_clr;
    logic [CNT_W-1:0]     tmr_term;
    logic                 tmr_tick;

    uart_rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .term  (tmr_term),
        .tick  (tmr_tick)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        tmr_clr      = 1'b0;
        tmr_term     = FULL_TERM;

        case (state_q)
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (rx_fall) begin
                    state_d   = ST_START;
                    par_err_d = 1'b0;
                end
            end
            ST_START: begin
                tmr_term = HALF_TERM;
                if (tmr_tick) begin
                    if (rx_level) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end
            // Bits arrive LSB first; shifting in from the top leaves the
            // first bit at bit 0 once all DATA_BITS have been taken.
            ST_DATA: begin
                if (tmr_tick) begin
                    shift_d = {rx_level, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (tmr_tick) begin
                    par_err_d = (rx_level != ((^shift_q) ^ PAR_ODD));
                    state_d   = ST_STOP;
                end
            end
            // Leave at mid stop bit so a back-to-back start edge is caught.
            ST_STOP: begin
                if (tmr_tick) begin
                    rx_data_d    = shift_q;
                    rx_valid_d   = rx_level & ~par_err_q;
                    frame_err_d  = ~rx_level;
                    parity_err_d = par_err_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rx_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive framer that turns the synchronized serial RX line into parallel bytes. It sits directly downstream of the RX edge-detector stage: it uses that stage's falling-edge pulse as the start-bit trigger and samples the level itself at mid-bit. Received bytes and error flags go up to the APB register/FIFO layer.

## Interface
- CLKS_PER_BIT, 16: clock cycles per UART bit; must be ≥ 4.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: parity sense when PARITY_EN = 1. 1 = odd, 0 = even.

- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset; synchronous, active-low.
- rx_level  input  1  synchronized RX line; idle = 1.
- rx_fall  input  1  one-cycle falling-edge pulse on rx_level, from the edge-detector stage.
- rx_data  output  DATA_BITS  last received data, LSB = first bit on the wire.
- rx_valid  output  1  one-cycle pulse: rx_data holds a good frame.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err  output  1  one-cycle pulse: parity mismatch. Always 0 when PARITY_EN = 0.
- rx_busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- HALF = CLKS_PER_BIT/2 (integer division).
- Bit counter: width $clog2(CLKS_PER_BIT). Index counter: width $clog2(DATA_BITS+1).
- **IDLE**
  - rx_fall = 1 → START, with cnt = 0.
  - rx_fall is ignored in every other state.
- **START** (false-start check)
  - When cnt == HALF-1, sample rx_level.
  - Sample 1 → IDLE, no outputs.
  - Sample 0 → DATA, with cnt = 0 and idx = 0.
- **DATA**
  - When cnt == CLKS_PER_BIT-1, sample rx_level into shift[idx], then idx+1 and cnt = 0.
  - After DATA_BITS samples → PARITY if PARITY_EN, else STOP.
- **PARITY**
  - Sample at cnt == CLKS_PER_BIT-1.
  - Error when sampled bit ≠ (^shift) ^ PARITY_ODD.
  - Latch the error flag internally → STOP.
- **STOP**
  - Sample at cnt == CLKS_PER_BIT-1.
  - Next cycle: rx_data <= shift, every time, including on error.
  - rx_valid = stop bit 1 AND no parity error.
  - frame_err = stop bit 0.
  - parity_err = latched parity error.
  - frame_err and parity_err may pulse in the same cycle.
  - FSM returns to IDLE on the sample cycle, i.e. at mid stop bit. A new rx_fall is therefore accepted from the cycle after the stop sample (back-to-back frames).
- Reset mid-frame: FSM to IDLE, partial byte discarded, no pulse emitted.

## Timing
- Reset values:
  - rx_data = 0
  - rx_valid = 0
  - frame_err = 0
  - parity_err = 0
  - rx_busy = 0
  - state = IDLE, cnt = 0, idx = 0
- Let rx_fall be high in cycle 0 while in IDLE, and P = PARITY_EN. Then:
  - Cycle 1: START, rx_busy = 1.
  - Start bit sampled in cycle HALF.
  - Data bit k sampled in cycle HALF + (k+1)·CLKS_PER_BIT.
  - Stop bit sampled in cycle HALF + (DATA_BITS+P+1)·CLKS_PER_BIT.
  - rx_valid / error pulses and the rx_data update occur in the next cycle. rx_busy is 0 in that same cycle.
- Defaults (16, 8, P = 0): pulse in cycle 153.
- All outputs are registered; none depends combinationally on inputs.
- rx_data holds its value between frames.

## Structure
- Shared package uart_pkg holds:
  - state enum (IDLE/START/DATA/PARITY/STOP, 3-bit encoding);
  - default CLKS_PER_BIT and DATA_BITS constants, shared with the TX side.
- One sub-module, uart_rx_bit_timer:
  - parameterized counter with clear and a terminal-compare input (HALF-1 or CLKS_PER_BIT-1);
  - issues a one-cycle sample strobe;
  - reused by the TX framer.
- Everything else is in the top module.

## Test plan
- **Basic byte**
  - Stimulus: reset; idle line; send 0xA5 (8N1, CPB = 16) with a matching rx_fall.
  - Response: rx_valid pulse in cycle 153 after rx_fall; rx_data = 0xA5; no errors.
- **False start**
  - Stimulus: rx_level low for 4 cycles with rx_fall, then high.
  - Response: FSM back to IDLE after 8 cycles; no pulses; rx_busy 1 then 0.
- **Framing error**
  - Stimulus: send 0x3C with stop bit held 0.
  - Response: frame_err pulse; rx_valid = 0; rx_data = 0x3C.
- **Parity** (PARITY_EN = 1, PARITY_ODD = 0)
  - Stimulus: send 0x07 with parity bit 1, then 0x07 with parity bit 0.
  - Response: first frame gives rx_valid; second gives parity_err with no rx_valid.
- **Back-to-back frames**
  - Stimulus: 0x55 then 0xAA, with the second start bit right after a one-bit stop.
  - Response: two rx_valid pulses exactly 10·CPB = 160 cycles apart, with data 0x55 then 0xAA.
- **Reset mid-frame**
  - Stimulus: deassert rst_n during data bit 4; release; send 0x81.
  - Response: no pulse for the aborted frame; next rx_valid carries 0x81.
